// File: rtl/axi4l_regbank.sv
// axi4l_regbank: AXI4-Lite slave exposing NUM_REGS control/status registers.
// Ports: aclk/areset (async, active-high); AXI4-Lite AW/W/B/AR/R channels;
//   reg_out (register i at [i*DATA_WIDTH +: DATA_WIDTH]), reg_in (status for
//   RO_MASK registers), wr_pulse (one-cycle strobe per successful write).
// Option: `define AXI4L_REGBANK_WSTRB_EN for byte-lane write strobes;
//   otherwise every write replaces the full word.
module axi4l_regbank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int LSB = $clog2(DATA_WIDTH/8);
  localparam int SW  = DATA_WIDTH/8;
`ifdef AXI4L_REGBANK_WSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  typedef enum logic {W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wst, wst_nxt;
  rstate_t rst, rst_nxt;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_have, w_have;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [SW-1:0]         w_strb_q;
  logic                  aw_take, w_take, commit;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_idx;
  logic [DATA_WIDTH-1:0] wr_data, wr_old, wr_merged;
  logic [SW-1:0]         wr_strb;
  logic [NUM_REGS-1:0]   wr_hit;
  logic [1:0]            wr_resp;

  logic                  ar_take, rd_dec;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH-1:0] rd_val;

  logic unused_ok;
  assign unused_ok = ^{awprot, arprot, reg_in};

  // Handshake/commit terms come from state and valids only, so they never
  // loop back through the ready outputs.
  assign aw_take = (wst == W_COLLECT) && !aw_have && awvalid;
  assign w_take  = (wst == W_COLLECT) && !w_have && wvalid;
  assign commit  = (wst == W_COLLECT) && (aw_have || awvalid) && (w_have || wvalid);
  assign ar_take = (rst == R_IDLE) && arvalid;

  assign wr_addr = aw_have ? aw_addr_q : awaddr;
  assign wr_data = w_have ? w_data_q : wdata;
  assign wr_strb = w_have ? w_strb_q : wstrb;

  always_comb begin
    wr_idx    = wr_addr >> LSB;
    wr_hit    = '0;
    wr_old    = '0;
    wr_resp   = 2'b00;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_idx == ADDR_WIDTH'(i)) begin
        wr_hit[i] = 1'b1;
        wr_old    = regs[i];
      end
    end
    if (wr_hit == '0)
      wr_resp = 2'b11;
    else if ((wr_hit & RO_MASK) != '0)
      wr_resp = 2'b10;
    wr_merged = wr_old;
    for (int unsigned b = 0; b < SW; b++) begin
      if (!STRB_EN || wr_strb[b])
        wr_merged[b*8 +: 8] = wr_data[b*8 +: 8];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) wst <= W_COLLECT;
    else        wst <= wst_nxt;
  end

  always_comb begin
    wst_nxt = wst;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    case (wst)
      W_COLLECT: begin
        awready = !aw_have;
        wready  = !w_have;
        if (commit) wst_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) wst_nxt = W_COLLECT;
      end
      default: wst_nxt = W_COLLECT;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_have   <= 1'b0;
      w_have    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp     <= 2'b00;
      wr_pulse  <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit) begin
        aw_have  <= 1'b0;
        w_have   <= 1'b0;
        bresp    <= wr_resp;
        wr_pulse <= (wr_resp == 2'b00) ? wr_hit : '0;
      end else begin
        if (aw_take) begin
          aw_have   <= 1'b1;
          aw_addr_q <= awaddr;
        end
        if (w_take) begin
          w_have   <= 1'b1;
          w_data_q <= wdata;
          w_strb_q <= wstrb;
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= RO_MASK[i] ? '0 : RESET_VAL;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (RO_MASK[i])
          regs[i] <= reg_in[i*DATA_WIDTH +: DATA_WIDTH];
        else if (commit && wr_hit[i])
          regs[i] <= wr_merged;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REGS; i++)
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

  always_comb begin
    rd_idx = araddr >> LSB;
    rd_val = '0;
    rd_dec = 1'b1;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == ADDR_WIDTH'(i)) begin
        rd_dec = 1'b0;
        rd_val = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) rst <= R_IDLE;
    else        rst <= rst_nxt;
  end

  always_comb begin
    rst_nxt = rst;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (rst)
      R_IDLE: begin
        arready = 1'b1;
        if (ar_take) rst_nxt = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) rst_nxt = R_IDLE;
      end
      default: rst_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rdata <= '0;
      rresp <= 2'b00;
    end else if (ar_take) begin
      rdata <= rd_val;
      rresp <= rd_dec ? 2'b11 : 2'b00;
    end
  end

endmodule

// File: tb/tb_axi4l_regbank.sv
// tb_axi4l_regbank: directed + randomized bench for axi4l_regbank with an
// array-based reference model of the register bank.
module tb_axi4l_regbank;
  localparam int              DW = 32;
  localparam int              AW = 32;
  localparam int              NR = 16;
  localparam logic [NR-1:0]   RO = 16'h0021;
  localparam logic [DW-1:0]   RV = 32'hA5A5_0F0F;
`ifdef AXI4L_REGBANK_WSTRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif

  logic            aclk = 1'b0;
  logic            areset = 1'b0;
  logic [AW-1:0]   awaddr = '0;
  logic [2:0]      awprot = '0;
  logic            awvalid = 1'b0;
  logic            awready;
  logic [DW-1:0]   wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic            wvalid = 1'b0;
  logic            wready;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready = 1'b0;
  logic [AW-1:0]   araddr = '0;
  logic [2:0]      arprot = '0;
  logic            arvalid = 1'b0;
  logic            arready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready = 1'b0;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] reg_in = '0;
  logic [NR-1:0]   wr_pulse;

  axi4l_regbank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
                  .RO_MASK(RO), .RESET_VAL(RV)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  always #5 aclk = ~aclk;

  int ncmp = 0;
  int nfail = 0;
  logic [DW-1:0] mregs [NR];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rin(input int unsigned i);
    return reg_in[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rout(input int unsigned i);
    return reg_out[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                          input logic [3:0] strb);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (!STRB_EN || strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) mregs[i] = RV;
  endtask

  function automatic logic [1:0] m_resp(input logic [31:0] addr, input bit is_wr);
    int unsigned idx;
    idx = addr >> 2;
    if (idx >= NR) return 2'b11;
    if (is_wr && RO[idx]) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [31:0] addr);
    int unsigned idx;
    idx = addr >> 2;
    if (idx >= NR) return '0;
    if (RO[idx]) return rin(idx);
    return mregs[idx];
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0]    eresp;
    logic [NR-1:0] epulse;
    int unsigned   idx;
    bit            awd, wdn;
    int            cyc;
    idx    = addr >> 2;
    eresp  = m_resp(addr, 1'b1);
    epulse = '0;
    if (eresp == 2'b00) begin
      epulse[idx] = 1'b1;
      mregs[idx]  = merge(mregs[idx], data, strb);
    end
    awd = 1'b0; wdn = 1'b0; cyc = 0;
    while (!(awd && wdn) && cyc < 64) begin
      @(negedge aclk);
      if (awd) check("awready_low_after_aw", 64'(awready), 64'(0));
      if (wdn) check("wready_low_after_w", 64'(wready), 64'(0));
      awaddr  = addr; wdata = data; wstrb = strb;
      awvalid = !awd && (cyc >= aw_dly);
      wvalid  = !wdn && (cyc >= w_dly);
      if (awvalid && awready) awd = 1'b1;
      if (wvalid && wready) wdn = 1'b1;
      cyc++;
    end
    check("write_handshake_done", 64'({awd, wdn}), 64'(2'b11));
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid_n_plus_1", 64'(bvalid), 64'(1));
    check("bresp", 64'(bresp), 64'(eresp));
    check("wr_pulse", 64'(wr_pulse), 64'(epulse));
    if (idx < NR) check("reg_out_after_write", 64'(rout(idx)), 64'(RO[idx] ? rin(idx) : mregs[idx]));
    for (int k = 0; k < b_dly; k++) begin
      bready = 1'b0;
      @(negedge aclk);
      check("bvalid_hold", 64'(bvalid), 64'(1));
      check("bresp_hold", 64'(bresp), 64'(eresp));
      check("wr_pulse_single", 64'(wr_pulse), 64'(0));
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_clear", 64'(bvalid), 64'(0));
    check("awready_back", 64'({awready, wready}), 64'(2'b11));
    check("wr_pulse_clear", 64'(wr_pulse), 64'(0));
  endtask

  task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
    logic [DW-1:0] edata;
    logic [1:0]    eresp;
    bit            ard;
    int            cyc;
    ard = 1'b0; cyc = 0; edata = '0; eresp = 2'b00;
    while (!ard && cyc < 64) begin
      @(negedge aclk);
      araddr  = addr;
      arvalid = (cyc >= ar_dly);
      if (arvalid && arready) begin
        ard   = 1'b1;
        edata = m_read(addr);
        eresp = m_resp(addr, 1'b0);
      end
      cyc++;
    end
    check("read_handshake_done", 64'(ard), 64'(1));
    @(negedge aclk);
    arvalid = 1'b0;
    check("rvalid_n_plus_1", 64'(rvalid), 64'(1));
    check("arready_busy", 64'(arready), 64'(0));
    check("rdata", 64'(rdata), 64'(edata));
    check("rresp", 64'(rresp), 64'(eresp));
    for (int k = 0; k < r_dly; k++) begin
      @(negedge aclk);
      check("rvalid_hold", 64'(rvalid), 64'(1));
      check("rdata_hold", 64'(rdata), 64'(edata));
      check("rresp_hold", 64'(rresp), 64'(eresp));
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    check("rvalid_clear", 64'(rvalid), 64'(0));
    check("arready_back", 64'(arready), 64'(1));
  endtask

  initial begin
    logic [DW-1:0] old4, new4;
    logic [31:0]   addr, data;

    for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = $urandom;
    reg_in[0*DW +: DW] = 32'h0000_1234;
    m_reset();

    // reset state
    #1 areset = 1'b1;
    #1;
    check("rst_ready", 64'({awready, wready, arready}), 64'(3'b111));
    check("rst_valid", 64'({bvalid, rvalid}), 64'(2'b00));
    check("rst_resp", 64'({bresp, rresp}), 64'(4'b0000));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_wr_pulse", 64'(wr_pulse), 64'(0));
    check("rst_reg3", 64'(rout(3)), 64'(RV));
    check("rst_ro0", 64'(rout(0)), 64'(0));
    @(negedge aclk); @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("ro_mirror", 64'(rout(0)), 64'(rin(0)));

    // directed
    axi_read(32'h0000_000C, 0, 0);
    axi_write(32'h0000_0008, 32'hDEAD_BEEF, 4'hF, 3, 0, 0);
    check("reg2_value", 64'(rout(2)), 64'(32'hDEAD_BEEF));
    axi_read(32'h0000_0008, 0, 2);
    axi_read(32'h0000_000B, 1, 0);
    axi_write(32'h0000_0000, 32'h0000_0055, 4'hF, 0, 2, 3);
    check("ro0_unchanged", 64'(rout(0)), 64'(32'h0000_1234));
    axi_read(32'h0000_0000, 0, 0);
    axi_write(32'h0000_0040, 32'h1111_2222, 4'hF, 0, 0, 0);
    axi_read(32'h0000_0040, 0, 1);
    axi_read(32'hFFFF_0008, 0, 0);
    axi_write(32'h0000_0018, 32'h1122_3344, 4'hF, 0, 0, 0);
    axi_write(32'h0000_0018, 32'hAABB_CCDD, 4'b0101, 1, 0, 0);
    check("wstrb_merge", 64'(rout(6)), 64'(STRB_EN ? 32'h11BB_33DD : 32'hAABB_CCDD));

    // read and write commit in the same cycle: read sees pre-write value
    old4 = mregs[4];
    new4 = $urandom;
    @(negedge aclk);
    awaddr = 32'h10; wdata = new4; wstrb = 4'hF; araddr = 32'h10;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    mregs[4] = merge(old4, new4, 4'hF);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("concurrent_rdata_old", 64'(rdata), 64'(old4));
    check("concurrent_bvalid", 64'({bvalid, rvalid}), 64'(2'b11));
    check("concurrent_reg4_new", 64'(rout(4)), 64'(mregs[4]));
    bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    bready = 1'b0; rready = 1'b0;
    check("concurrent_clear", 64'({bvalid, rvalid}), 64'(2'b00));

    // reset while a write response is stalled
    @(negedge aclk);
    awaddr = 32'h1C; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_bvalid", 64'(bvalid), 64'(1));
      @(negedge aclk);
    end
    #2 areset = 1'b1;
    #1;
    m_reset();
    check("arst_bvalid", 64'(bvalid), 64'(0));
    check("arst_ready", 64'({awready, wready, arready}), 64'(3'b111));
    check("arst_pulse", 64'(wr_pulse), 64'(0));
    check("arst_reg7", 64'(rout(7)), 64'(RV));
    check("arst_reg2", 64'(rout(2)), 64'(RV));
    check("arst_ro0", 64'(rout(0)), 64'(0));
    @(negedge aclk);
    areset = 1'b0;
    axi_read(32'h0000_001C, 0, 0);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < NR; i++) reg_in[i*DW +: DW] = $urandom;
      addr = ($urandom_range(0, 19) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) addr = addr | 32'h0100_0000;
      data = $urandom;
      if ($urandom_range(0, 1) == 1)
        axi_write(addr, data, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2));
      else
        axi_read(addr, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    @(negedge aclk);
    for (int i = 0; i < NR; i++)
      check("final_reg_out", 64'(rout(i)), 64'(RO[i] ? rin(i) : mregs[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi4l_regbank.md
# axi4l_regbank

- Parametrised AXI4-Lite slave that exposes a bank of `NUM_REGS` control/status registers to fabric logic.
- Accepts the write-address and write-data channels independently and in either order, with one outstanding write and one outstanding read.
- Supports per-register read-only status words and returns error responses for invalid accesses.
- Sits behind the AXI4-Lite interconnect as the standard register front-end for new IP blocks.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width; 32 or 64.
- `ADDR_WIDTH`, 32: address bus width.
- `NUM_REGS`, 16: number of registers; ≥2, power of two not required.
- `RO_MASK`, 0: `NUM_REGS`-bit mask; bit i=1 makes register i read-only (value taken from `reg_in`).
- `RESET_VAL`, 0: `DATA_WIDTH` reset value of every writable register.

Ports:
- `aclk` in 1: clock.
- `areset` in 1: reset; asynchronous, active-high.
- `awaddr` in `ADDR_WIDTH`, `awprot` in 3 (ignored), `awvalid` in 1, `awready` out 1: write-address channel.
- `wdata` in `DATA_WIDTH`, `wstrb` in `DATA_WIDTH/8`, `wvalid` in 1, `wready` out 1: write-data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write-response channel.
- `araddr` in `ADDR_WIDTH`, `arprot` in 3 (ignored), `arvalid` in 1, `arready` out 1: read-address channel.
- `rdata` out `DATA_WIDTH`, `rresp` out 2, `rvalid` out 1, `rready` in 1: read-data channel.
- `reg_out` out `NUM_REGS*DATA_WIDTH`: register i at bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `reg_in` in `NUM_REGS*DATA_WIDTH`: status inputs; only slices for `RO_MASK` bits are used.
- `wr_pulse` out `NUM_REGS`: one-cycle strobe on a successful write to register i.

## Operation

**Address decode**
- `LSB = clog2(DATA_WIDTH/8)`; index = `addr >> LSB`.
- Low `LSB` address bits are ignored.
- index ≥ `NUM_REGS` (including nonzero upper bits) → DECERR (2'b11).
- Write to an `RO_MASK` register → SLVERR (2'b10), no state change.
- Otherwise → OKAY (2'b00).

**Write FSM: `W_COLLECT` → `W_RESP` → `W_COLLECT`**
- In `W_COLLECT`, an AW handshake latches the address and drops `awready`; a W handshake latches data/strobe and drops `wready`. The two may occur in the same cycle or in any order.
- When both are latched, the write is performed on the next edge and the FSM moves to `W_RESP`: `bvalid`=1, `bresp` per decode, `wr_pulse[i]`=1 for one cycle if OKAY.
- `bvalid` and `bresp` hold until `bready`. On the B handshake, return to `W_COLLECT` with `awready`=`wready`=1 next cycle.

**Read FSM: `R_IDLE` → `R_DATA` → `R_IDLE`**
- In `R_IDLE`, `arready`=1. An AR handshake captures `rdata` (register, `reg_in` slice for RO, 0 for DECERR) and `rresp`, then moves to `R_DATA`.
- In `R_DATA`, `rvalid`=1 and `arready`=0. `rdata`/`rresp` stay stable until `rready`.

**Concurrency**
- Read and write paths are fully independent.
- A read whose AR handshake is in the same cycle as a write commit returns the pre-write value.

## Timing
- Reset values: `awready`=`wready`=`arready`=1; `bvalid`=`rvalid`=0; `bresp`=`rresp`=0; `rdata`=0; `wr_pulse`=0; writable registers=`RESET_VAL`; RO slices of `reg_out`=0.
- AW+W handshake in cycle N: register updated, `bvalid`=1 and `wr_pulse` high in cycle N+1.
- AR handshake in cycle N: `rvalid`=1 in cycle N+1.
- With `bready`/`rready` held high: one write per 2 cycles and one read per 2 cycles.
- Reset asserted mid-transaction: all FSMs return to idle asynchronously, pending transactions are dropped, outputs take reset values.
- `reg_out` for RO registers mirrors `reg_in` combinationally-free (registered one cycle).

## Configuration
- `AXI4L_REGBANK_WSTRB_EN` defined: only bytes with `wstrb[k]`=1 are updated. `wstrb`=0 still returns OKAY and pulses `wr_pulse` with no data change.
- Undefined: `wstrb` is ignored and every write replaces the full word.

## Test plan
- Reset, then read reg 3 at `0x0C` → `rdata`=`RESET_VAL`, `rresp`=OKAY, `rvalid` at N+1.
- W presented 3 cycles before AW: write `0xDEADBEEF` to `0x08` → `reg_out[2]`=`0xDEADBEEF`, one `wr_pulse[2]`, `bresp`=OKAY; readback matches.
- `RO_MASK`=1: write `0x55` to `0x00` → `bresp`=SLVERR, `reg_out[0]` unchanged; read `0x00` with `reg_in[0]`=`0x1234` → `0x1234`.
- Read/write `0x40` with `NUM_REGS`=16 → DECERR on both, `rdata`=0, no `wr_pulse`.
- With `WSTRB_EN`: `wstrb`=`4'b0101`, `wdata`=`0xAABBCCDD` over `0x11223344` → `0x11BB33DD`. Without `WSTRB_EN` → `0xAABBCCDD`.
- `bready` held low 5 cycles, then `areset` pulsed → `bvalid`=0, `awready`=1, registers=`RESET_VAL`.
